// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions: S-box, word helpers, Rcon and FSM states.
package aes_key_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Round constants; entry i is used when producing round key i+1 (forward direction).
  localparam logic [31:0] RCON [NR] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  // FIPS-197 S-box, row = high nibble, column = low nibble.
  localparam logic [0:15][0:15][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b[7:4]][b[3:0]];
  endfunction

  function automatic logic [31:0] rotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Out-of-range indices (e.g. a wrapped round-1 at round 0) yield zero.
  function automatic logic [31:0] rconWord(input logic [3:0] i);
    logic [31:0] r;
    r = 32'h0;
    if (i < 4'(NR)) r = RCON[i];
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the key-schedule walker and its host/consumer.
interface aes_inv_key_schedule_if;
  logic         start;
  logic         keyMode;
  logic [127:0] keyIn;
  logic [127:0] keyOut;
  logic [3:0]   keyRound;
  logic         keyValid;
  logic         keyReady;
  logic         busy;
  logic         done;

  modport master (
    output start, keyMode, keyIn, keyReady,
    input  keyOut, keyRound, keyValid, busy, done
  );

  modport slave (
    input  start, keyMode, keyIn, keyReady,
    output keyOut, keyRound, keyValid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_round.sv
// Combinational inverse key-expansion step: round key roundCount -> roundCount-1.
module aes_inv_key_round
  import aes_key_pkg::*;
(
  input  logic [3:0]   roundCount,
  input  logic [127:0] keyIn,
  output logic [127:0] keyOut
);

  logic [31:0] w [NK];
  logic [31:0] a_n, b_n, c_n, d_n;

  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_word
      assign w[gi] = keyIn[32*(NK-1-gi) +: 32];
    end
  endgenerate

  // Undo the xor cascade first; the new word 3 feeds the SubWord/Rcon term for word 0.
  always_comb begin
    d_n    = w[3] ^ w[2];
    c_n    = w[2] ^ w[1];
    b_n    = w[1] ^ w[0];
    a_n    = w[0] ^ subWord(rotWord(d_n)) ^ rconWord(roundCount - 4'd1);
    keyOut = {a_n, b_n, c_n, d_n};
  end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 key schedule walked in decryption order: emits round keys 10 down to 0.
module aes_inv_key_schedule
  import aes_key_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetN,
  aes_inv_key_schedule_if.slave bus
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [127:0] fwd_key, inv_key;
  logic [31:0]  fw_t, fw4, fw5, fw6, fw7;

  aes_inv_key_round u_inv_round (
    .roundCount (round_q),
    .keyIn      (key_q),
    .keyOut     (inv_key)
  );

  // One forward expansion round, key_q (round r) -> round r+1, used while in EXPAND.
  always_comb begin
    fw_t    = subWord(rotWord(key_q[31:0])) ^ rconWord(round_q);
    fw4     = key_q[127:96] ^ fw_t;
    fw5     = key_q[95:64]  ^ fw4;
    fw6     = key_q[63:32]  ^ fw5;
    fw7     = key_q[31:0]   ^ fw6;
    fwd_key = {fw4, fw5, fw6, fw7};
  end

  // Next-state and next-output logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d = bus.keyIn;
          if (bus.keyMode) begin
            round_d = 4'd0;
            valid_d = 1'b0;
            state_d = EXPAND;
          end else begin
            round_d = LAST_RND;
            valid_d = 1'b1;
            state_d = EMIT;
          end
        end
      end

      EXPAND: begin
        key_d   = fwd_key;
        round_d = round_q + 4'd1;
        if (round_q == LAST_RND - 4'd1) begin
          valid_d = 1'b1;
          state_d = EMIT;
        end
      end

      EMIT: begin
        if (bus.keyReady) begin
          if (round_q != 4'd0) begin
            key_d   = inv_key;
            round_d = round_q - 4'd1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State/output registers; the asynchronous clear discards any partial schedule.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.keyOut   = key_q;
  assign bus.keyRound = round_q;
  assign bus.keyValid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: FIPS-197 vectors plus randomized keys and throttling,
// checked against a forward key expansion built from GF(2^8) arithmetic.
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if bus ();

  aes_inv_key_schedule dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]   sbox_m [256];
  logic [7:0]   rc_m [10];
  logic [127:0] exp_rk [11];

  logic [127:0] got_key [16];
  logic [3:0]   got_round [16];
  int n_got, first_lat, stable_err, busy_err, done_cnt, valid_after;
  bit timed_out;

  localparam logic [127:0] FIPS_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box = affine transform of the multiplicative inverse; Rcon = successive powers of x.
  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc_m[0] = 8'h01;
    for (int j = 1; j < 10; j++) rc_m[j] = gf_mul(rc_m[j-1], 8'h02);
  endtask

  // Full 44-word forward expansion; exp_rk[r] is round key r.
  task automatic model_expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
            ^ {rc_m[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus driver (records, does not judge) ----------------
  // Called at a negedge. Launches one schedule and consumes keys with pct% ready.
  task automatic run_schedule(input logic mode, input logic [127:0] k, input int pct, input bit spam);
    bit last_acc, prev_stall, rdy;
    int tail;
    logic [127:0] pk;
    logic [3:0] pr;
    for (int i = 0; i < 16; i++) begin got_key[i] = 'x; got_round[i] = 'x; end
    n_got = 0; first_lat = -1; stable_err = 0; busy_err = 0; done_cnt = 0; valid_after = 0;
    timed_out = 0; last_acc = 0; prev_stall = 0; tail = 0; pk = '0; pr = '0;
    bus.start = 1'b1; bus.keyMode = mode; bus.keyIn = k; bus.keyReady = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (spam && !last_acc) begin
        bus.start   = 1'($urandom_range(1));
        bus.keyMode = 1'($urandom_range(1));
        bus.keyIn   = rand128();
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) done_cnt++;
      if (last_acc) begin
        if (bus.keyValid) valid_after++;
        bus.keyReady = 1'b0;
        tail++;
        if (tail == 3) break;
      end else begin
        if (bus.busy !== 1'b1) busy_err++;
        if (bus.keyValid) begin
          if (first_lat < 0) first_lat = cyc;
          if (prev_stall && (bus.keyOut !== pk || bus.keyRound !== pr)) stable_err++;
          rdy = ($urandom_range(99) < pct);
          bus.keyReady = rdy;
          if (rdy) begin
            if (n_got < 16) begin
              got_key[n_got]   = bus.keyOut;
              got_round[n_got] = bus.keyRound;
            end
            n_got++;
            if (bus.keyRound == 4'd0) last_acc = 1;
          end
          prev_stall = !rdy;
          pk = bus.keyOut;
          pr = bus.keyRound;
        end else begin
          bus.keyReady = 1'($urandom_range(1));
          prev_stall = 0;
        end
      end
    end
    if (!(last_acc && tail == 3)) timed_out = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start = 1'b0; bus.keyMode = 1'b0; bus.keyIn = '0; bus.keyReady = 1'b0;
    #1 resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.keyOut !== 128'h0) begin failures++; $display("FAIL reset_keyOut got=%h expected=0", bus.keyOut); end
    checks++; if (bus.keyRound !== 4'h0) begin failures++; $display("FAIL reset_keyRound got=%0d expected=0", bus.keyRound); end
    checks++; if (bus.keyValid !== 1'b0) begin failures++; $display("FAIL reset_keyValid got=%b expected=0", bus.keyValid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b expected=0", bus.done); end
    resetN = 1'b1;
    bus.keyReady = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.keyValid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL idle_ignores_ready got valid=%b busy=%b expected valid=0 busy=0", bus.keyValid, bus.busy);
    end
    bus.keyReady = 1'b0;
    $display("test_reset: idle outputs checked");
  endtask

  task automatic test_fips_expand();
    model_expand(FIPS_CK);
    run_schedule(1'b1, FIPS_CK, 100, 1'b0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL fips_expand_timeout got=1 expected=0"); end
    checks++; if (first_lat !== 11) begin failures++; $display("FAIL fips_expand_latency got=%0d expected=11", first_lat); end
    checks++; if (n_got !== 11) begin failures++; $display("FAIL fips_expand_count got=%0d expected=11", n_got); end
    checks++; if (got_key[0] !== FIPS_R10) begin failures++; $display("FAIL fips_round10 got=%h expected=%h", got_key[0], FIPS_R10); end
    checks++; if (got_key[1] !== FIPS_R9) begin failures++; $display("FAIL fips_round9 got=%h expected=%h", got_key[1], FIPS_R9); end
    checks++; if (got_key[10] !== FIPS_CK) begin failures++; $display("FAIL fips_round0 got=%h expected=%h", got_key[10], FIPS_CK); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL fips_expand_done got=%0d expected=1", done_cnt); end
    checks++; if (busy_err !== 0 || valid_after !== 0) begin failures++; $display("FAIL fips_expand_busy got busy_err=%0d valid_after=%0d expected=0", busy_err, valid_after); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_round[i] !== 4'(10 - i) || got_key[i] !== exp_rk[10-i]) begin
        failures++; $display("FAIL fips_expand_seq[%0d] got r=%0d k=%h expected r=%0d k=%h", i, got_round[i], got_key[i], 10 - i, exp_rk[10-i]);
      end
    end
    $display("test_fips_expand: %0d keys, first valid after %0d cycles", n_got, first_lat);
  endtask

  task automatic test_fips_direct();
    model_expand(FIPS_CK);
    run_schedule(1'b0, FIPS_R10, 100, 1'b0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL fips_direct_timeout got=1 expected=0"); end
    checks++; if (first_lat !== 1) begin failures++; $display("FAIL fips_direct_latency got=%0d expected=1", first_lat); end
    checks++; if (got_key[9] !== FIPS_R1) begin failures++; $display("FAIL fips_direct_round1 got=%h expected=%h", got_key[9], FIPS_R1); end
    checks++; if (got_key[10] !== FIPS_CK) begin failures++; $display("FAIL fips_direct_round0 got=%h expected=%h", got_key[10], FIPS_CK); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL fips_direct_done got=%0d expected=1", done_cnt); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_round[i] !== 4'(10 - i) || got_key[i] !== exp_rk[10-i]) begin
        failures++; $display("FAIL fips_direct_seq[%0d] got r=%0d k=%h expected r=%0d k=%h", i, got_round[i], got_key[i], 10 - i, exp_rk[10-i]);
      end
    end
    $display("test_fips_direct: %0d keys, first valid after %0d cycles", n_got, first_lat);
  endtask

  task automatic test_throttled();
    logic [127:0] ck;
    logic mode;
    for (int run = 0; run < 4; run++) begin
      mode = 1'(run % 2);
      ck = rand128();
      model_expand(ck);
      run_schedule(mode, mode ? ck : exp_rk[10], 30, 1'b0);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL throttled_timeout run=%0d got=1 expected=0", run); end
      checks++; if (first_lat !== (mode ? 11 : 1)) begin failures++; $display("FAIL throttled_latency run=%0d got=%0d expected=%0d", run, first_lat, mode ? 11 : 1); end
      checks++; if (n_got !== 11) begin failures++; $display("FAIL throttled_count run=%0d got=%0d expected=11", run, n_got); end
      checks++; if (stable_err !== 0) begin failures++; $display("FAIL throttled_stall_stable run=%0d got=%0d expected=0", run, stable_err); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL throttled_done run=%0d got=%0d expected=1", run, done_cnt); end
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (got_round[i] !== 4'(10 - i) || got_key[i] !== exp_rk[10-i]) begin
          failures++; $display("FAIL throttled_seq run=%0d [%0d] got r=%0d k=%h expected r=%0d k=%h", run, i, got_round[i], got_key[i], 10 - i, exp_rk[10-i]);
        end
      end
      $display("test_throttled: run %0d mode=%0d key=%h keys=%0d", run, mode, ck, n_got);
    end
  endtask

  task automatic test_start_ignored();
    logic [127:0] ck;
    logic mode;
    for (int run = 0; run < 2; run++) begin
      mode = 1'(1 - run);
      ck = rand128();
      model_expand(ck);
      run_schedule(mode, mode ? ck : exp_rk[10], 50, 1'b1);
      checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL start_ign_timeout run=%0d got=1 expected=0", run); end
      checks++; if (n_got !== 11) begin failures++; $display("FAIL start_ign_count run=%0d got=%0d expected=11", run, n_got); end
      checks++; if (busy_err !== 0) begin failures++; $display("FAIL start_ign_busy run=%0d got=%0d expected=0", run, busy_err); end
      checks++; if (done_cnt !== 1 || valid_after !== 0) begin failures++; $display("FAIL start_ign_done run=%0d got done=%0d valid_after=%0d expected done=1 valid_after=0", run, done_cnt, valid_after); end
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (got_round[i] !== 4'(10 - i) || got_key[i] !== exp_rk[10-i]) begin
          failures++; $display("FAIL start_ign_seq run=%0d [%0d] got r=%0d k=%h expected r=%0d k=%h", run, i, got_round[i], got_key[i], 10 - i, exp_rk[10-i]);
        end
      end
      $display("test_start_ignored: run %0d mode=%0d keys=%0d", run, mode, n_got);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    model_expand(rand128());
    bus.start = 1'b1; bus.keyMode = 1'b0; bus.keyIn = exp_rk[10]; bus.keyReady = 1'b1;
    hit = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.keyValid && bus.keyRound == 4'd5) begin hit = 1; break; end
    end
    bus.keyReady = 1'b0;
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL async_reach_round5 got=0 expected=1"); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (bus.keyOut !== 128'h0 || bus.keyRound !== 4'h0) begin
      failures++; $display("FAIL async_key_clear got k=%h r=%0d expected k=0 r=0", bus.keyOut, bus.keyRound);
    end
    checks++; if (bus.keyValid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL async_flags_clear got v=%b b=%b d=%b expected 0 0 0", bus.keyValid, bus.busy, bus.done);
    end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.keyValid !== 1'b0) begin
      failures++; $display("FAIL async_idle_after got busy=%b valid=%b expected 0 0", bus.busy, bus.keyValid);
    end
    model_expand(rand128());
    run_schedule(1'b0, exp_rk[10], 100, 1'b0);
    checks++; if (timed_out !== 1'b0 || n_got !== 11 || first_lat !== 1) begin
      failures++; $display("FAIL async_restart got to=%b n=%0d lat=%0d expected to=0 n=11 lat=1", timed_out, n_got, first_lat);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_round[i] !== 4'(10 - i) || got_key[i] !== exp_rk[10-i]) begin
        failures++; $display("FAIL async_restart_seq[%0d] got r=%0d k=%h expected r=%0d k=%h", i, got_round[i], got_key[i], 10 - i, exp_rk[10-i]);
      end
    end
    $display("test_async_reset: reset at round 5, restart produced %0d keys", n_got);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    logic [127:0] last_key;
    bit hit, done_seen;
    int n;
    model_expand(rand128());
    k1 = exp_rk[10];
    model_expand(rand128());
    k2 = exp_rk[10];
    bus.start = 1'b1; bus.keyMode = 1'b0; bus.keyIn = k1; bus.keyReady = 1'b1;
    hit = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.keyValid && bus.keyRound == 4'd0) begin
        hit = 1; bus.start = 1'b1; bus.keyIn = k2;
        break;
      end
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL b2b_reach_round0 got=0 expected=1"); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.keyValid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL b2b_start_with_final got d=%b v=%b b=%b expected d=1 v=0 b=0", bus.done, bus.keyValid, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.keyValid !== 1'b1 || bus.keyRound !== 4'd10 || bus.keyOut !== k2 || bus.done !== 1'b0) begin
      failures++; $display("FAIL b2b_next_start got v=%b r=%0d k=%h d=%b expected v=1 r=10 k=%h d=0", bus.keyValid, bus.keyRound, bus.keyOut, bus.done, k2);
    end
    n = 1; done_seen = 0; last_key = bus.keyOut;
    for (int i = 0; i < 30 && !done_seen; i++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1;
      else if (bus.keyValid) begin n++; last_key = bus.keyOut; end
    end
    checks++; if (done_seen !== 1'b1 || n !== 11) begin
      failures++; $display("FAIL b2b_drain got done=%b n=%0d expected done=1 n=11", done_seen, n);
    end
    checks++; if (last_key !== exp_rk[0]) begin
      failures++; $display("FAIL b2b_round0 got=%h expected=%h", last_key, exp_rk[0]);
    end
    bus.keyReady = 1'b0;
    $display("test_back_to_back: second schedule drained %0d keys", n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_tables();
    test_reset();
    test_fips_expand();
    test_fips_direct();
    test_throttled();
    test_start_ignored();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
